// File: rtl/cache_defines_pkg.sv
// rtl/cache_defines_pkg.sv - shared line/beat geometry and FSM encodings for the cache memory arbiter
package cache_defines_pkg;

  localparam int CACHE_DATA_WIDTH = 32;
  localparam int CACHE_LINE_SIZE  = 512;
  localparam int CACHE_BEATS      = CACHE_LINE_SIZE / CACHE_DATA_WIDTH;
  localparam int CACHE_OFFSET_W   = $clog2(CACHE_LINE_SIZE / 8);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/line_beat_buffer.sv
// rtl/line_beat_buffer.sv - burst beat counter plus line buffer shared by refills and writebacks
module line_beat_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 512
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   load_i,
  input  logic [LINE_SIZE-1:0]                   wline_i,
  input  logic                                   beat_en_i,
  input  logic                                   store_i,
  input  logic [DATA_WIDTH-1:0]                  rdata_i,
  output logic [$clog2(LINE_SIZE/DATA_WIDTH)-1:0] beat_o,
  output logic                                   last_o,
  output logic [LINE_SIZE-1:0]                   line_o,
  output logic [DATA_WIDTH-1:0]                  wdata_o
);

  localparam int BEATS  = LINE_SIZE / DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);

  logic [BEAT_W-1:0]    count_q, count_d;
  logic [LINE_SIZE-1:0] line_q, line_d;

  assign last_o  = (count_q == BEAT_W'(BEATS - 1));
  assign beat_o  = count_q;
  assign line_o  = line_q;
  assign wdata_o = line_q[int'(count_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    count_d = count_q;
    line_d  = line_q;
    if (beat_en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
      if (store_i) line_d[int'(count_q)*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
    end
    // A writeback line is loaded at grant, before any beat can be acknowledged
    if (load_i) line_d = wline_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      line_q  <= '0;
    end else begin
      count_q <= count_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - arbitrates icache/dcache line transfers onto one beat-wide memory bus
// Optional round-robin between simultaneous requesters: CACHE_ARB_RR_EN
module cache_mem_arbiter
  import cache_defines_pkg::*;
#(
  parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int LINE_SIZE  = CACHE_LINE_SIZE,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_gnt,
  output logic                  ic_valid,
  output logic [LINE_SIZE-1:0]  ic_line,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_SIZE-1:0]  dc_wline,
  output logic                  dc_gnt,
  output logic                  dc_valid,
  output logic [LINE_SIZE-1:0]  dc_line,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int BEATS      = LINE_SIZE / DATA_WIDTH;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_SIZE / 8 - 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  sel_dc, sel_ic;
  logic                  load_wline, beat_en, store_beat, last_beat;
  logic [BEAT_W-1:0]     beat;
  logic [LINE_SIZE-1:0]  line_buf;
  logic [DATA_WIDTH-1:0] wdata;

`ifdef CACHE_ARB_RR_EN
  logic last_dc_q, last_dc_d;
  // The requester not served most recently wins a tie
  assign sel_dc = dc_req && (!ic_req || !last_dc_q);
`else
  assign sel_dc = dc_req;
`endif
  assign sel_ic = ic_req && !sel_dc;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    base_d     = base_q;
    ic_gnt     = 1'b0;
    dc_gnt     = 1'b0;
    ic_valid   = 1'b0;
    dc_valid   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    load_wline = 1'b0;
    beat_en    = 1'b0;
`ifdef CACHE_ARB_RR_EN
    last_dc_d  = last_dc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Grants are combinational, so they must be masked while reset is held
        if (!reset && sel_dc) begin
          dc_gnt     = 1'b1;
          owner_d    = OWN_DC;
          base_d     = dc_addr & ~OFFSET_MASK;
          load_wline = dc_we;
          state_d    = dc_we ? ST_WR_BURST : ST_RD_BURST;
`ifdef CACHE_ARB_RR_EN
          last_dc_d  = 1'b1;
`endif
        end else if (!reset && sel_ic) begin
          ic_gnt     = 1'b1;
          owner_d    = OWN_IC;
          base_d     = ic_addr & ~OFFSET_MASK;
          state_d    = ST_RD_BURST;
`ifdef CACHE_ARB_RR_EN
          last_dc_d  = 1'b0;
`endif
        end
      end
      ST_RD_BURST, ST_WR_BURST: begin
        mem_req = 1'b1;
        mem_we  = (state_q == ST_WR_BURST);
        beat_en = mem_ack;
        if (mem_ack && last_beat) state_d = ST_RESP;
      end
      ST_RESP: begin
        ic_valid = (owner_q == OWN_IC);
        dc_valid = (owner_q == OWN_DC);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IC;
      base_q    <= '0;
`ifdef CACHE_ARB_RR_EN
      last_dc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      base_q    <= base_d;
`ifdef CACHE_ARB_RR_EN
      last_dc_q <= last_dc_d;
`endif
    end
  end

  assign store_beat = (state_q == ST_RD_BURST);

  line_beat_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINE_SIZE (LINE_SIZE)
  ) u_line_beat_buffer (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (load_wline),
    .wline_i  (dc_wline),
    .beat_en_i(beat_en),
    .store_i  (store_beat),
    .rdata_i  (mem_rdata),
    .beat_o   (beat),
    .last_o   (last_beat),
    .line_o   (line_buf),
    .wdata_o  (wdata)
  );

  // base_q is line aligned, so OR-ing in the beat offset is an add
  assign mem_addr  = mem_req ? (base_q | (ADDR_WIDTH'(beat) << BEAT_SHIFT)) : '0;
  assign mem_wdata = mem_we ? wdata : '0;
  assign ic_line   = line_buf;
  assign dc_line   = line_buf;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - randomized self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam int DW = 32;
  localparam int LS = 512;
  localparam int AW = 32;
  localparam int NB = LS / DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, ic_gnt, ic_valid;
  logic [AW-1:0] ic_addr;
  logic [LS-1:0] ic_line;
  logic          dc_req, dc_we, dc_gnt, dc_valid;
  logic [AW-1:0] dc_addr;
  logic [LS-1:0] dc_wline, dc_line;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit last_dc   = 1'b0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.DATA_WIDTH(DW), .LINE_SIZE(LS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_valid(ic_valid), .ic_line(ic_line),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wline(dc_wline),
    .dc_gnt(dc_gnt), .dc_valid(dc_valid), .dc_line(dc_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // ack_mode: 0 = ack every cycle, 1 = hold ack low 3 cycles at beat 5, 2 = random
  task automatic run_txn(input bit rq_ic, input bit rq_dc, input bit we,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [LS-1:0] wl, input int ack_mode, input bit idx_data,
                         input string tag);
    bit            win_dc, got, ack, is_wr;
    logic [AW-1:0] base, exp_addr;
    logic [LS-1:0] exp_line;
    logic [DW-1:0] rd;
    int            beat, cyc, stall;
    if (rq_ic && rq_dc) begin
`ifdef CACHE_ARB_RR_EN
      win_dc = !last_dc;
`else
      win_dc = 1'b1;
`endif
    end else win_dc = rq_dc;
    is_wr = win_dc && we;
    base  = (win_dc ? da : ia) & ~(AW'(LS / 8 - 1));
    exp_line = is_wr ? wl : '0;

    @(posedge clk); #1;
    ic_req = rq_ic; ic_addr = ia;
    dc_req = rq_dc; dc_addr = da; dc_we = we; dc_wline = wl;
    mem_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (ic_gnt || dc_gnt) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total_cnt++;
    if (!got) begin
      $display("FAIL %s grant_timeout: no grant within 40 cycles", tag);
      ic_req = 1'b0; dc_req = 1'b0;
      return;
    end else pass_cnt++;
    total_cnt++;
    if ({dc_gnt, ic_gnt} !== (win_dc ? 2'b10 : 2'b01))
      $display("FAIL %s winner: gnt {dc,ic}=%b required %b", tag, {dc_gnt, ic_gnt}, (win_dc ? 2'b10 : 2'b01));
    else pass_cnt++;
    last_dc = win_dc;

    @(posedge clk); #1;
    if (win_dc) dc_req = 1'b0; else ic_req = 1'b0;
    beat = 0; cyc = 0; stall = 0;
    while (beat < NB && cyc < 300) begin
      case (ack_mode)
        0: ack = 1'b1;
        1: begin ack = !(beat == 5 && stall < 3); if (!ack) stall++; end
        default: ack = ($urandom_range(0, 3) != 0);
      endcase
      rd = idx_data ? DW'(beat) : DW'($urandom);
      mem_ack = ack; mem_rdata = rd;
      exp_addr = base + AW'(4 * beat);
      #1;
      total_cnt++;
      if (mem_req !== 1'b1 || mem_we !== is_wr || mem_addr !== exp_addr)
        $display("FAIL %s beat%0d_bus: req=%b we=%b addr=%h required req=1 we=%b addr=%h",
                 tag, beat, mem_req, mem_we, mem_addr, is_wr, exp_addr);
      else pass_cnt++;
      total_cnt++;
      if (ic_gnt || dc_gnt || ic_valid || dc_valid)
        $display("FAIL %s beat%0d_quiet: gnt=%b%b valid=%b%b required all 0",
                 tag, beat, dc_gnt, ic_gnt, dc_valid, ic_valid);
      else pass_cnt++;
      if (is_wr) begin
        total_cnt++;
        if (mem_wdata !== wl[beat*DW +: DW])
          $display("FAIL %s beat%0d_wdata: got %h required %h", tag, beat, mem_wdata, wl[beat*DW +: DW]);
        else pass_cnt++;
      end
      if (ack) begin
        if (!is_wr) exp_line[beat*DW +: DW] = rd;
        beat++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    #1;
    total_cnt++;
    if (ic_valid !== !win_dc || dc_valid !== win_dc || mem_req !== 1'b0 || ic_gnt || dc_gnt)
      $display("FAIL %s resp: valid {dc,ic}=%b%b mem_req=%b gnt=%b%b required valid %b%b, req 0, gnt 00",
               tag, dc_valid, ic_valid, mem_req, dc_gnt, ic_gnt, win_dc, !win_dc);
    else pass_cnt++;
    total_cnt++;
    if (ic_line !== exp_line || dc_line !== exp_line)
      $display("FAIL %s line: ic_line=%h dc_line=%h required %h", tag, ic_line, dc_line, exp_line);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wline = '0; mem_ack = 1'b1; mem_rdata = '1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({ic_gnt, ic_valid, dc_gnt, dc_valid, mem_req, mem_we} !== 6'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || ic_line !== '0 || dc_line !== '0)
      $display("FAIL reset_outputs: gnt=%b%b valid=%b%b req=%b addr=%h required all 0",
               dc_gnt, ic_gnt, dc_valid, ic_valid, mem_req, mem_addr);
    else pass_cnt++;
    ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b0;
    reset = 1'b0;
    last_dc = 1'b0;
  endtask

  task automatic test_ic_refill();
    run_txn(1'b1, 1'b0, 1'b0, 32'h8000_1234, '0, '0, 0, 1'b1, "ic_refill");
  endtask

  task automatic test_ack_stall();
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0FC4, '0, '0, 1, 1'b0, "ack_stall");
  endtask

  task automatic test_dc_writeback();
    logic [LS-1:0] wl;
    for (int k = 0; k < NB; k++) wl[k*DW +: DW] = DW'(32'hA0 + k);
    run_txn(1'b0, 1'b1, 1'b1, '0, 32'h0000_0040, wl, 0, 1'b0, "dc_writeback");
  endtask

  task automatic test_arbitration();
    run_txn(1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h2000_0040, '0, 0, 1'b0, "arb_first");
    run_txn(1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h2000_0040, '0, 0, 1'b0, "arb_second");
    ic_req = 1'b0; dc_req = 1'b0;
  endtask

  task automatic test_reset_midburst();
    bit got = 1'b0;
    int bad = 0;
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 32'h0000_3000;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (ic_gnt) got = 1'b1; else begin @(posedge clk); #1; end
    end
    total_cnt++;
    if (!got) $display("FAIL midreset_grant: ic_gnt never seen");
    else pass_cnt++;
    @(posedge clk); #1;
    for (int b = 0; b < 8; b++) begin
      mem_ack = 1'b1; mem_rdata = DW'($urandom);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    #1;
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3020)
      $display("FAIL midreset_beat8: req=%b addr=%h required req=1 addr=00003020", mem_req, mem_addr);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || ic_gnt !== 1'b0 || ic_valid !== 1'b0 || ic_line !== '0)
      $display("FAIL midreset_outputs: req=%b addr=%h gnt=%b valid=%b line_nz=%b required all 0",
               mem_req, mem_addr, ic_gnt, ic_valid, |ic_line);
    else pass_cnt++;
    ic_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_dc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ic_valid || dc_valid || mem_req) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL midreset_abandon: %0d cycles with activity, required 0", bad);
    else pass_cnt++;
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_3000, '0, '0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [LS-1:0] wl;
    bit            rq_ic, rq_dc;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < NB; k++) wl[k*DW +: DW] = DW'($urandom);
      case ($urandom_range(0, 2))
        0: begin rq_ic = 1'b1; rq_dc = 1'b0; end
        1: begin rq_ic = 1'b0; rq_dc = 1'b1; end
        default: begin rq_ic = 1'b1; rq_dc = 1'b1; end
      endcase
      run_txn(rq_ic, rq_dc, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
              wl, 2, 1'b0, $sformatf("random%0d", t));
    end
    ic_req = 1'b0; dc_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ic_refill();
    test_ack_stall();
    test_dc_writeback();
    test_arbitration();
    test_reset_midburst();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
